// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types for the staged reset sequencer
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT,
        WAIT,
        RUN,
        FAULT
    } reset_seq_state_t;

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - control/status bundle between sequencer and reset domains
interface reset_sequencer_if #(
    parameter int STAGES = 3
);
    logic                        sw_reset_req;
    logic [STAGES-1:0]           stage_done;
    logic [STAGES-1:0]           stage_reset;
    logic                        ready;
    logic                        fault;
    logic [$clog2(STAGES)-1:0]   fault_stage;

    modport master (
        input  sw_reset_req,
        input  stage_done,
        output stage_reset,
        output ready,
        output fault,
        output fault_stage
    );

    modport slave (
        output sw_reset_req,
        output stage_done,
        input  stage_reset,
        input  ready,
        input  fault,
        input  fault_stage
    );
endinterface

// File: rtl/reset_seq_timer.sv
// rtl/reset_seq_timer.sv - saturating loadable up-counter with clear and terminal match
module reset_seq_timer #(
    parameter int MAX_COUNT = 1,
    parameter int WIDTH     = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             match,
    output logic             zero
);
    localparam logic [WIDTH-1:0] TERM = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count;

    // Clear wins over load; counting stops at the terminal value so it never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != TERM)) begin
            count <= count + 1'b1;
        end
    end

    assign match = (count == TERM);
    assign zero  = (count == '0);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered release of reset domains with hold time and per-stage watchdog
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int STAGES         = 3,
    parameter int HOLD_CYCLES    = 15,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    reset_sequencer_if.master  bus
);
    localparam int IDX_W                = $clog2(STAGES);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(STAGES - 1);
    localparam int HOLD_MAX             = HOLD_CYCLES - 1;
    // With the watchdog off the timer only has to tell "zero" from "non-zero".
    localparam int WD_MAX               = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES - 1;

    reset_seq_state_t   state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [STAGES-1:0]  stage_reset_q, stage_reset_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;
    logic [IDX_W-1:0]   fault_stage_q, fault_stage_d;
    logic               accept;
    logic               hold_match, hold_zero;
    logic               wd_match, wd_zero;

    // The hold counter runs only in ASSERT; it is parked at zero everywhere else.
    reset_seq_timer #(.MAX_COUNT(HOLD_MAX)) u_hold (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (bus.sw_reset_req || hold_match || ((state_q != ASSERT) && !hold_zero)),
        .en         (state_q == ASSERT),
        .load       (1'b0),
        .load_value ('0),
        .match      (hold_match),
        .zero       (hold_zero)
    );

    // The watchdog measures cycles since the current stage was released.
    reset_seq_timer #(.MAX_COUNT(WD_MAX)) u_watchdog (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (bus.sw_reset_req || (state_q != WAIT) || accept),
        .en         (1'b1),
        .load       (1'b0),
        .load_value ('0),
        .match      (wd_match),
        .zero       (wd_zero)
    );

    // State and every output are registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ASSERT;
            idx_q         <= '0;
            stage_reset_q <= '1;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
            fault_stage_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            stage_reset_q <= stage_reset_d;
            ready_q       <= ready_d;
            fault_q       <= fault_d;
            fault_stage_q <= fault_stage_d;
        end
    end

    // Next-state logic; a software request overrides whatever else happens this cycle.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        stage_reset_d = stage_reset_q;
        ready_d       = ready_q;
        fault_d       = fault_q;
        fault_stage_d = fault_stage_q;
        accept        = 1'b0;

        if (bus.sw_reset_req) begin
            state_d       = ASSERT;
            idx_d         = '0;
            stage_reset_d = '1;
            ready_d       = 1'b0;
            fault_d       = 1'b0;
            fault_stage_d = '0;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (hold_match) begin
                        stage_reset_d[0] = 1'b0;
                        idx_d            = '0;
                        state_d          = WAIT;
                    end
                end
                WAIT: begin
                    // The first cycle after a release never accepts, so a stale done can't skip a stage.
                    if (!wd_zero && bus.stage_done[idx_q]) begin
                        accept = 1'b1;
                        if (idx_q == LAST) begin
                            ready_d = 1'b1;
                            state_d = RUN;
                        end else begin
                            stage_reset_d[idx_q + 1'b1] = 1'b0;
                            idx_d                       = idx_q + 1'b1;
                        end
                    end else if ((TIMEOUT_CYCLES != 0) && wd_match) begin
                        fault_d       = 1'b1;
                        fault_stage_d = idx_q;
                        state_d       = FAULT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.stage_reset = stage_reset_q;
    assign bus.ready       = ready_q;
    assign bus.fault       = fault_q;
    assign bus.fault_stage = fault_stage_q;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged power-up reset controller that replaces a single free-running reset with an ordered release of several downstream reset domains. It holds every domain in reset for a fixed number of cycles, then releases the domains one at a time. Each domain must report ready before the next domain is released. It sits at the top level between the board clock/reset and the SRAM, display and application subsystems. It also supports a synchronous software-requested re-sequence and a per-stage watchdog.

## Interface
- `STAGES`, default 3: number of reset domains; must be at least 2.
- `HOLD_CYCLES`, default 15: cycles all domains stay in reset before stage 0 is released; must be at least 1.
- `TIMEOUT_CYCLES`, default 0: per-stage ready watchdog. 0 disables it; otherwise it must be at least 2.
- `clk`, input, 1: system clock; the only clock.
- `reset_n`, input, 1: asynchronous, active-low reset. Deassertion is synchronized upstream; this block does not resynchronize it.
- `sw_reset_req`, input, 1: synchronous single-cycle request to restart the whole sequence.
- `stage_done`, input, `STAGES`: per-domain ready. Synchronous to `clk`, level-sensitive.
- `stage_reset`, output, `STAGES`: per-domain reset, active-high, registered.
- `ready`, output, 1: all domains released and all have reported done. Registered.
- `fault`, output, 1: the watchdog expired. Registered, sticky.
- `fault_stage`, output, `$clog2(STAGES)`: index of the stage that timed out. Valid while `fault` is high.

## Operation
- States: ASSERT, WAIT, RUN, FAULT.
- `reset_n` low, applied asynchronously:
  - state becomes ASSERT;
  - hold counter, stage index and watchdog timer all clear to 0;
  - `stage_reset` = all ones, `ready` = 0, `fault` = 0, `fault_stage` = 0.
- ASSERT:
  - the hold counter increments each cycle;
  - on the edge where the counter equals `HOLD_CYCLES-1`: clear `stage_reset[0]`, set index 0, clear timer, go to WAIT.
- WAIT (current index i):
  - the timer increments each cycle;
  - `stage_done[i]` is ignored while the timer is 0;
  - when the timer is non-zero and `stage_done[i]` = 1:
    - if i < `STAGES-1`: clear `stage_reset[i+1]`, increment the index, clear the timer, stay in WAIT;
    - if i = `STAGES-1`: set `ready`, go to RUN.
  - when the watchdog is enabled, `stage_done[i]` = 0 and the timer equals `TIMEOUT_CYCLES-1`: set `fault`, load `fault_stage` = i, go to FAULT.
- RUN: all `stage_reset` bits are low and `ready` stays high. Later changes on `stage_done` are ignored.
- FAULT:
  - stages 0..i remain released;
  - stages above i remain in reset;
  - `ready` stays 0;
  - the block stays in FAULT until `sw_reset_req` or `reset_n`.
- `sw_reset_req`, in any state, takes priority over every other event in the same cycle:
  - at the next edge, all `stage_reset` go high, `ready` and `fault` clear, the counter clears, and the state becomes ASSERT;
  - if it arrives while already in ASSERT, the hold count restarts from 0.
- Stage releases are strictly ordered. A `stage_done` bit for an index other than the current one never affects sequencing.

## Timing
- Edges are counted from the first rising edge after `reset_n` deasserts, which is edge 1.
- `stage_reset[0]` falls at edge `HOLD_CYCLES`; call that edge H.
- With the current stage's `stage_done` held high, the next stage is released exactly 2 edges after the current one.
- With all `stage_done` tied high:
  - `stage_reset[k]` falls at edge H+2k;
  - `ready` rises at edge H+2·`STAGES`.
- Watchdog: a fault for stage i asserts exactly `TIMEOUT_CYCLES` edges after that stage's release edge.
- `sw_reset_req` sampled high at edge E gives `stage_reset` all high after E. A new release occurs at edge E+`HOLD_CYCLES`.
- Every output is registered; there are no combinational paths from input to output.

## Structure
- Package `reset_seq_pkg` holds the state enum typedef, `reset_seq_state_t` (ASSERT, WAIT, RUN, FAULT).
- One sub-module, `reset_seq_timer`: a loadable up-counter with clear and a terminal-match output.
  - one instance serves as the hold counter;
  - a second instance serves as the watchdog timer.
  - it is sized with `$clog2` of its maximum count plus 1.

## Test plan
- `reset_n` pulse with defaults (`STAGES`=3, `HOLD_CYCLES`=15) and `stage_done` = 3'b111 → `stage_reset` falls at edges 15, 17 and 19; `ready` rises at edge 21.
- `stage_done[1]` held low for 10 cycles after its release, then raised → `stage_reset[2]` falls 1 edge after `stage_done[1]` is sampled high; it never falls early.
- `TIMEOUT_CYCLES`=8 with `stage_done[2]` stuck low → `fault` = 1 and `fault_stage` = 2, 8 edges after stage 2's release. `stage_reset` = 3'b000 with `ready` = 0; a following `sw_reset_req` restarts the sequence and clears `fault`.
- `sw_reset_req` in RUN → `stage_reset` = 3'b111 and `ready` = 0 next cycle; re-release at +15 edges.
- `sw_reset_req` coincident with the accepting `stage_done` in WAIT → the request wins and the state returns to ASSERT.
- `reset_n` asserted mid-WAIT → outputs return to their reset values asynchronously, without waiting for a clock edge.
